// File: rtl/fibo_seq_gen.sv
// fibo_seq_gen: WIDTH-bit LED sequence generator (Fibonacci, Lucas or up-counter).
// The sequence advances on an internal clock-enable divider in RUN, or one term per
// step pulse in IDLE/HOLD.
// Ports:
//   clk, reset (async, active-low)
//   mode[1:0]  0 Fibonacci, 1 Lucas, 2 up-counter, 3 Fibonacci
//   start/stop/step/clear  synchronous control (priority clear > stop > start > step)
//   out[WIDTH-1:0]  current term (register b)
//   adv_o           one-cycle pulse in the cycle out shows a new term
//   ovf             sticky overflow flag
//   running         high while in RUN
module fibo_seq_gen #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DECIMATION = 16,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned WRAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             adv_o,
    output logic             ovf,
    output logic             running
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DECIMATION - 1);
    localparam logic [1:0]       MODE_CNT = 2'd2;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             adv_q, adv_d;
    logic             ovf_q, ovf_d;
    logic             running_q, running_d;
    logic             do_adv;
    logic [WIDTH:0]   sum;

    // Seed pair per mode: Fibonacci (0,1), Lucas (2,1), counter (0,0).
    function automatic logic [WIDTH-1:0] seed_a(input logic [1:0] m);
        return (m == 2'd1) ? WIDTH'(2) : '0;
    endfunction

    function automatic logic [WIDTH-1:0] seed_b(input logic [1:0] m);
        return (m == MODE_CNT) ? '0 : WIDTH'(1);
    endfunction

    // Candidate next term with carry-out for overflow detection.
    always_comb begin
        if (mode_q == MODE_CNT) begin
            sum = {1'b0, b_q} + (WIDTH + 1)'(1);
        end else begin
            sum = {1'b0, a_q} + {1'b0, b_q};
        end
    end

    // Next-state, sequencing and divider control.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        div_d   = div_q;
        ovf_d   = ovf_q;
        adv_d   = 1'b0;
        do_adv  = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            a_d     = seed_a(mode_q);
            b_d     = seed_b(mode_q);
            ovf_d   = 1'b0;
            div_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    mode_d = mode;
                    // A mode change reloads the seed; a step in that same cycle only moves to HOLD.
                    if (mode != mode_q) begin
                        a_d = seed_a(mode);
                        b_d = seed_b(mode);
                    end
                    if (start) begin
                        state_d = ST_RUN;
                        div_d   = '0;
                    end else if (step) begin
                        state_d = ST_HOLD;
                        do_adv  = (mode == mode_q);
                    end
                end
                ST_RUN: begin
                    // stop beats a coincident tick; the divider stays frozen in HOLD.
                    if (stop) begin
                        state_d = ST_HOLD;
                    end else if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        do_adv = 1'b1;
                    end else begin
                        div_d = div_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (start) begin
                        state_d = ST_RUN;
                        div_d   = '0;
                    end else if (step) begin
                        do_adv = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (do_adv) begin
                adv_d = 1'b1;
                if (!sum[WIDTH]) begin
                    if (mode_q != MODE_CNT) begin
                        a_d = b_q;
                    end
                    b_d = sum[WIDTH-1:0];
                end else begin
                    ovf_d = 1'b1;
                    if (WRAP != 0) begin
                        a_d = b_q;
                        b_d = sum[WIDTH-1:0];
                    end else begin
                        a_d = seed_a(mode_q);
                        b_d = seed_b(mode_q);
                    end
                end
            end
        end

        running_d = (state_d == ST_RUN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= 2'd0;
            a_q       <= '0;
            b_q       <= WIDTH'(1);
            div_q     <= '0;
            adv_q     <= 1'b0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            div_q     <= div_d;
            adv_q     <= adv_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
        end
    end

    assign out     = b_q;
    assign adv_o   = adv_q;
    assign ovf     = ovf_q;
    assign running = running_q;

endmodule

// File: tb/tb_fibo_seq_gen.sv
// Bench for fibo_seq_gen: two instances (restart and modulo overflow policy) share
// directed stimulus; a term-level model is compared every cycle, plus literal checks.
module tb_fibo_seq_gen;

    localparam int W    = 8;
    localparam int D    = 16;
    localparam int MAXV = 1 << W;

    logic         clk, reset, start, stop, step, clear;
    logic [1:0]   mode;
    logic [W-1:0] out0, out1;
    logic         adv0, adv1, ovf0, ovf1, run0, run1;

    int n_checks = 0;
    int n_err    = 0;

    fibo_seq_gen #(.WIDTH(W), .DECIMATION(D), .CNT_W(20), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .mode(mode), .start(start), .stop(stop),
        .step(step), .clear(clear), .out(out0), .adv_o(adv0), .ovf(ovf0), .running(run0));

    fibo_seq_gen #(.WIDTH(W), .DECIMATION(D), .CNT_W(20), .WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .mode(mode), .start(start), .stop(stop),
        .step(step), .clear(clear), .out(out1), .adv_o(adv1), .ovf(ovf1), .running(run1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Term-level model: 0 idle, 1 run, 2 hold; m_clk counts clocks since entering RUN.
    int m_st[2], m_mode[2], m_a[2], m_b[2], m_clk[2];
    int m_ovf[2], m_adv[2];

    task automatic load_seed(input int w, input int md);
        m_a[w] = (md == 1) ? 2 : 0;
        m_b[w] = (md == 2) ? 0 : 1;
    endtask

    task automatic next_term(input int w);
        int nxt;
        m_adv[w] = 1;
        nxt = (m_mode[w] == 2) ? m_b[w] + 1 : m_a[w] + m_b[w];
        if (nxt >= MAXV) begin
            m_ovf[w] = 1;
            if (w == 1) begin
                m_a[w] = m_b[w];
                m_b[w] = nxt - MAXV;
            end else begin
                load_seed(w, m_mode[w]);
            end
        end else begin
            if (m_mode[w] != 2) m_a[w] = m_b[w];
            m_b[w] = nxt;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        for (int w = 0; w < 2; w++) begin
            if (!reset) begin
                m_st[w] = 0; m_mode[w] = 0; m_a[w] = 0; m_b[w] = 1;
                m_clk[w] = 0; m_ovf[w] = 0; m_adv[w] = 0;
            end else begin
                m_adv[w] = 0;
                if (clear) begin
                    m_st[w] = 0; load_seed(w, m_mode[w]); m_ovf[w] = 0; m_clk[w] = 0;
                end else if (m_st[w] == 0) begin
                    if (int'(mode) != m_mode[w]) begin
                        m_mode[w] = int'(mode);
                        load_seed(w, m_mode[w]);
                        if (start) begin m_st[w] = 1; m_clk[w] = 0; end
                        else if (step) m_st[w] = 2;
                    end else if (start) begin
                        m_st[w] = 1; m_clk[w] = 0;
                    end else if (step) begin
                        m_st[w] = 2; next_term(w);
                    end
                end else if (m_st[w] == 1) begin
                    if (stop) m_st[w] = 2;
                    else begin
                        m_clk[w]++;
                        if (m_clk[w] == D) begin m_clk[w] = 0; next_term(w); end
                    end
                end else begin
                    if (start) begin m_st[w] = 1; m_clk[w] = 0; end
                    else if (step) next_term(w);
                end
            end
        end
    end

    // Every-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        chk("d0.out", int'(out0), m_b[0] == 0 && m_mode[0] != 2 ? 0 : m_b[0]);
        chk("d0.adv", int'(adv0), m_adv[0]);
        chk("d0.ovf", int'(ovf0), m_ovf[0]);
        chk("d0.run", int'(run0), m_st[0] == 1 ? 1 : 0);
        chk("d1.out", int'(out1), m_b[1]);
        chk("d1.adv", int'(adv1), m_adv[1]);
        chk("d1.ovf", int'(ovf1), m_ovf[1]);
        chk("d1.run", int'(run1), m_st[1] == 1 ? 1 : 0);
    end

    task automatic pulse(input int which);
        @(posedge clk); #2;
        case (which)
            0: start = 1'b1;
            1: stop  = 1'b1;
            2: step  = 1'b1;
            default: clear = 1'b1;
        endcase
        @(posedge clk); #2;
        start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0;
    endtask

    task automatic wait_adv(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!adv0 && cyc < limit);
    endtask

    int fib_exp[12] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    int luc_exp[4]  = '{3, 4, 7, 11};
    int cyc;

    initial begin
        reset = 1'b0; mode = 2'd0; start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Reset release and idle
        repeat (50) @(posedge clk);
        #2;
        chk("t1.out", int'(out0), 1);
        chk("t1.adv", int'(adv0), 0);
        chk("t1.run", int'(run0), 0);
        chk("t1.ovf", int'(ovf0), 0);

        // Fibonacci run, one term every D clocks
        pulse(0);
        for (int i = 0; i < 12; i++) begin
            wait_adv(40, cyc);
            chk("t2.lat", cyc, D);
            chk("t2.term0", int'(out0), fib_exp[i]);
            chk("t2.term1", int'(out1), fib_exp[i]);
        end

        // Overflow after 233
        wait_adv(40, cyc);
        chk("t3.lat", cyc, D);
        chk("t3.restart_out", int'(out0), 1);
        chk("t3.restart_ovf", int'(ovf0), 1);
        chk("t3.wrap_out", int'(out1), 121);
        chk("t3.wrap_ovf", int'(ovf1), 1);
        wait_adv(40, cyc);
        chk("t3.wrap_out2", int'(out1), 98);
        chk("t3.restart_out2", int'(out0), 1);
        pulse(3);
        chk("t3.clr_ovf0", int'(ovf0), 0);
        chk("t3.clr_ovf1", int'(ovf1), 0);
        chk("t3.clr_run", int'(run0), 0);

        // Lucas by single steps
        mode = 2'd1;
        repeat (3) @(posedge clk);
        #2 chk("t4.seed", int'(out0), 1);
        for (int i = 0; i < 4; i++) begin
            pulse(2);
            chk("t4.term0", int'(out0), luc_exp[i]);
            chk("t4.term1", int'(out1), luc_exp[i]);
            chk("t4.run", int'(run0), 0);
        end
        wait_adv(40, cyc);
        chk("t4.noadv", int'(adv0), 0);
        chk("t4.hold", int'(out0), 11);

        // Counter with stop/hold/resume
        pulse(3);
        mode = 2'd2;
        repeat (3) @(posedge clk);
        #2 chk("t5.seed", int'(out0), 0);
        pulse(0);
        for (int i = 1; i <= 3; i++) begin
            wait_adv(40, cyc);
            chk("t5.lat", cyc, D);
            chk("t5.term", int'(out0), i);
        end
        pulse(1);
        repeat (40) @(posedge clk);
        #2;
        chk("t5.held", int'(out0), 3);
        chk("t5.run", int'(run0), 0);
        pulse(0);
        wait_adv(40, cyc);
        chk("t5.resume_lat", cyc, D);
        chk("t5.resume", int'(out0), 4);

        // stop coincident with tick
        repeat (14) @(posedge clk);
        pulse(1);
        wait_adv(30, cyc);
        chk("t6.stoptick_adv", int'(adv0), 0);
        chk("t6.stoptick_out", int'(out0), 4);
        pulse(0);
        wait_adv(40, cyc);
        chk("t6.restart_lat", cyc, D);
        chk("t6.restart_out", int'(out0), 5);

        // clear mid-RUN
        pulse(3);
        chk("t6.clr_out", int'(out0), 0);
        chk("t6.clr_run", int'(run0), 0);
        chk("t6.clr_ovf", int'(ovf0), 0);

        // reset mid-RUN, asynchronous
        mode = 2'd0;
        repeat (2) @(posedge clk);
        #2 chk("t6.fibseed", int'(out0), 1);
        pulse(0);
        wait_adv(40, cyc);
        wait_adv(40, cyc);
        chk("t6.prerst", int'(out0), 2);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t6.rst_out0", int'(out0), 1);
        chk("t6.rst_out1", int'(out1), 1);
        chk("t6.rst_run", int'(run0), 0);
        chk("t6.rst_adv", int'(adv0), 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        wait_adv(40, cyc);
        chk("t6.release_adv", int'(adv0), 0);
        chk("t6.release_out", int'(out0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
